// File: rtl/spell_mem_pkg.sv
// Shared encodings for the SPELL memory router: address spaces, FSM states,
// error read data and the default access timeout.
package spell_mem_pkg;

  localparam logic [1:0] SPACE_DATA = 2'd0;
  localparam logic [1:0] SPACE_CODE = 2'd1;
  localparam logic [1:0] SPACE_IO   = 2'd2;
  localparam logic [1:0] SPACE_RSVD = 2'd3;

  localparam logic [7:0] ERR_RDATA = 8'hFF;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // Select vector layout is {io, code, data}
  function automatic logic [2:0] space_to_sel(input logic [1:0] space);
    logic [2:0] sel;
    case (space)
      SPACE_DATA: sel = 3'b001;
      SPACE_CODE: sel = 3'b010;
      SPACE_IO:   sel = 3'b100;
      default:    sel = 3'b000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/spell_mem_router.sv
// Single-access router from the SPELL CPU to data RAM, code memory and IO:
// decode, hold select until ready, one release cycle, timeout with error.
module spell_mem_router
  import spell_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_req,
  input  logic [1:0] cpu_space,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_write,
  output logic [7:0] cpu_rdata,
  output logic       cpu_done,
  output logic       cpu_err,
  output logic       data_select,
  output logic       code_select,
  output logic       io_select,
  output logic [7:0] tgt_addr,
  output logic [7:0] tgt_wdata,
  output logic       tgt_write,
  input  logic [7:0] data_rdata,
  input  logic [7:0] code_rdata,
  input  logic [7:0] io_rdata,
  input  logic       data_ready,
  input  logic       code_ready,
  input  logic       io_ready
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             write_q, write_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sel_ready_s;
  logic [7:0]       sel_rdata_s;
  logic             illegal_s;

  // Only the selected target's ready and read data are ever looked at
  always_comb begin
    sel_ready_s = |(sel_q & {io_ready, code_ready, data_ready});
    case (sel_q)
      3'b001:  sel_rdata_s = data_rdata;
      3'b010:  sel_rdata_s = code_rdata;
      3'b100:  sel_rdata_s = io_rdata;
      default: sel_rdata_s = 8'h00;
    endcase
  end

  assign illegal_s = (cpu_space == SPACE_RSVD) ||
                     ((cpu_space == SPACE_CODE) && cpu_write);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          write_d = cpu_write;
          cnt_d   = '0;
          if (illegal_s) begin
            sel_d   = 3'b000;
            done_d  = 1'b1;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
            state_d = ST_RELEASE;
          end else begin
            sel_d   = space_to_sel(cpu_space);
            state_d = ST_ACTIVE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (sel_ready_s) begin
          sel_d   = 3'b000;
          done_d  = 1'b1;
          state_d = ST_RELEASE;
          if (!write_q) begin
            rdata_d = sel_rdata_s;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          sel_d   = 3'b000;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Swallows a stale ready left over from the access just completed
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        sel_d   = 3'b000;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 3'b000;
      cnt_q   <= '0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      write_q <= 1'b0;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign data_select = sel_q[0];
  assign code_select = sel_q[1];
  assign io_select   = sel_q[2];
  assign tgt_addr    = addr_q;
  assign tgt_wdata   = wdata_q;
  assign tgt_write   = write_q;
  assign cpu_rdata   = rdata_q;
  assign cpu_done    = done_q;
  assign cpu_err     = err_q;

endmodule

// File: tb/tb_spell_mem_router.sv
// Directed bench for spell_mem_router: target models, a per-cycle expected
// schedule built from the access rules, and literal checks on key results.
module tb_spell_mem_router;

  localparam int TO = 15;
  localparam int NC = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu_req = 1'b0;
  logic [1:0] cpu_space = 2'd0;
  logic [7:0] cpu_addr = 8'h00;
  logic [7:0] cpu_wdata = 8'h00;
  logic       cpu_write = 1'b0;
  logic [7:0] cpu_rdata;
  logic       cpu_done, cpu_err;
  logic       data_select, code_select, io_select;
  logic [7:0] tgt_addr, tgt_wdata;
  logic       tgt_write;
  logic [7:0] data_rd, code_rd, io_rd;
  logic       data_rdy, code_rdy, io_rdy;

  logic       data_en = 1'b1;
  logic       code_en = 1'b1;
  logic [7:0] io_pins = 8'hA5;
  logic [7:0] io_port, io_ddr;
  logic [7:0] data_mem [0:255];

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  logic [2:0] exp_sel  [0:NC-1];
  logic [7:0] exp_addr [0:NC-1];
  logic [7:0] exp_wd   [0:NC-1];
  logic       exp_wr   [0:NC-1];
  logic       exp_done [0:NC-1];
  logic       exp_err  [0:NC-1];
  logic       exp_rdv  [0:NC-1];
  logic [7:0] exp_rd   [0:NC-1];
  logic       exp_rst  [0:NC-1];

  logic [7:0] last_rd;
  int         sel_cycles;

  spell_mem_router #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_space(cpu_space), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .data_select(data_select), .code_select(code_select), .io_select(io_select),
    .tgt_addr(tgt_addr), .tgt_wdata(tgt_wdata), .tgt_write(tgt_write),
    .data_rdata(data_rd), .code_rdata(code_rd), .io_rdata(io_rd),
    .data_ready(data_rdy), .code_ready(code_rdy), .io_ready(io_rdy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Target models: ready one cycle after select and held while select stays
  // high (so it is still high in the router's release cycle); IO port register
  // toggles by wdata on a write and must see only one toggle per access.
  always @(posedge clk) begin
    if (!rst_n) begin
      data_rdy <= 1'b0; code_rdy <= 1'b0; io_rdy <= 1'b0;
      data_rd <= 8'h00; code_rd <= 8'h00; io_rd <= 8'h00;
      io_port <= 8'h00; io_ddr <= 8'h3C;
      for (int i = 0; i < 256; i++) data_mem[i] <= 8'(i) ^ 8'h4A;
    end else begin
      data_rdy <= data_select & data_en;
      code_rdy <= code_select & code_en;
      io_rdy   <= io_select;
      if (data_select && !data_rdy) begin
        if (tgt_write) data_mem[tgt_addr] <= tgt_wdata;
        data_rd <= data_mem[tgt_addr];
      end
      if (code_select && !code_rdy) code_rd <= tgt_addr + 8'hA3;
      if (io_select && !io_rdy) begin
        if (tgt_write) begin
          if (tgt_addr == 8'h36) io_port <= io_port ^ tgt_wdata;
          else if (tgt_addr == 8'h37) io_ddr <= tgt_wdata;
        end else begin
          case (tgt_addr)
            8'h36:   io_rd <= io_pins;
            8'h37:   io_rd <= io_ddr;
            8'h38:   io_rd <= io_port;
            default: io_rd <= 8'h00;
          endcase
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, got, want);
    end
  endtask

  // Per-cycle compare against the expected schedule
  initial begin : compare
    logic [7:0] hold;
    hold = 8'h00;
    forever begin
      @(negedge clk);
      if (chk_on && cyc < NC) begin
        if (exp_rst[cyc]) hold = 8'h00;
        if (exp_rdv[cyc]) hold = exp_rd[cyc];
        chk("selects", {5'd0, io_select, code_select, data_select}, {5'd0, exp_sel[cyc]});
        chk("cpu_done", {7'd0, cpu_done}, {7'd0, exp_done[cyc]});
        chk("cpu_err", {7'd0, cpu_err}, {7'd0, exp_err[cyc]});
        chk("cpu_rdata", cpu_rdata, hold);
        if (exp_sel[cyc] != 3'b000) begin
          chk("tgt_addr", tgt_addr, exp_addr[cyc]);
          chk("tgt_wdata", tgt_wdata, exp_wd[cyc]);
          chk("tgt_write", {7'd0, tgt_write}, {7'd0, exp_wr[cyc]});
        end
        if (exp_rst[cyc]) begin
          chk("rst_tgt_addr", tgt_addr, 8'h00);
          chk("rst_tgt_wdata", tgt_wdata, 8'h00);
          chk("rst_tgt_write", {7'd0, tgt_write}, 8'h00);
        end
      end
    end
  end

  task automatic sched_done(input int idx, input logic err, input logic [7:0] rd, input logic upd);
    if (idx < NC) begin
      exp_done[idx] = 1'b1;
      exp_err[idx]  = err;
      exp_rdv[idx]  = upd;
      exp_rd[idx]   = rd;
    end
  endtask

  task automatic sched_sel(input int from, input int n, input logic [2:0] sel,
                           input logic [7:0] a, input logic [7:0] wd, input logic wr);
    for (int i = from; i < from + n && i < NC; i++) begin
      exp_sel[i] = sel; exp_addr[i] = a; exp_wd[i] = wd; exp_wr[i] = wr;
    end
  endtask

  // Called on a falling edge; reset is applied on the next n rising edges
  task automatic reset_pulse(input int n);
    int r;
    r = cyc + 1;
    for (int i = r; i < r + 64 && i < NC; i++) begin
      exp_sel[i] = 3'b000; exp_done[i] = 1'b0; exp_err[i] = 1'b0; exp_rdv[i] = 1'b0;
    end
    for (int i = r; i < r + n && i < NC; i++) exp_rst[i] = 1'b1;
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One CPU access issued on a falling edge; schedule derives from the rules:
  // illegal -> done next cycle; responding target -> 2 select cycles then done;
  // silent target -> TO select cycles then error done.
  task automatic do_access(input logic [1:0] sp, input logic [7:0] a, input logic [7:0] wd,
                           input logic wr, input logic [7:0] rd_exp, input logic hold_req);
    int t, n;
    logic [2:0] sel;
    logic illegal, responds;
    t = cyc + 1;
    cpu_req = 1'b1; cpu_space = sp; cpu_addr = a; cpu_wdata = wd; cpu_write = wr;
    illegal  = (sp == 2'd3) || (sp == 2'd1 && wr);
    responds = (sp == 2'd0 && data_en) || (sp == 2'd1 && code_en) || (sp == 2'd2);
    sel = (sp == 2'd0) ? 3'b001 : (sp == 2'd1) ? 3'b010 : 3'b100;
    if (illegal) begin
      sched_done(t, 1'b1, 8'hFF, 1'b1);
    end else if (responds) begin
      sched_sel(t, 2, sel, a, wd, wr);
      sched_done(t + 2, 1'b0, rd_exp, !wr);
    end else begin
      sched_sel(t, TO, sel, a, wd, wr);
      sched_done(t + TO, 1'b1, 8'hFF, 1'b1);
    end
    n = 0;
    sel_cycles = 0;
    do begin
      @(negedge clk);
      n++;
      if (data_select || code_select || io_select) sel_cycles++;
    end while (!cpu_done && n < 40);
    if (!cpu_done) begin
      n_checks++; n_fail++;
      $display("FAIL done_wait: no cpu_done within 40 cycles (space %0d addr %h)", sp, a);
    end
    last_rd = cpu_rdata;
    if (!hold_req) begin
      cpu_req = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    for (int i = 0; i < NC; i++) begin
      exp_sel[i] = 3'b000; exp_addr[i] = 8'h00; exp_wd[i] = 8'h00; exp_wr[i] = 1'b0;
      exp_done[i] = 1'b0; exp_err[i] = 1'b0; exp_rdv[i] = 1'b0; exp_rd[i] = 8'h00;
      exp_rst[i] = 1'b0;
    end
    @(negedge clk);
    chk_on = 1'b1;
    reset_pulse(2);

    // IO read of input pins
    do_access(2'd2, 8'h36, 8'h00, 1'b0, 8'hA5, 1'b0);
    chk("io_read_rdata", last_rd, 8'hA5);
    chk("io_read_sel_cycles", 8'(sel_cycles), 8'd2);

    // IO toggle write: a double write would toggle back to 0x00
    do_access(2'd2, 8'h36, 8'h0F, 1'b1, 8'h00, 1'b0);
    chk("io_port_toggle", io_port, 8'h0F);
    do_access(2'd2, 8'h38, 8'h00, 1'b0, 8'h0F, 1'b0);
    chk("io_port_readback", last_rd, 8'h0F);

    // Timeout on a silent data target
    data_en = 1'b0;
    do_access(2'd0, 8'h11, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("timeout_rdata", last_rd, 8'hFF);
    chk("timeout_sel_cycles", 8'(sel_cycles), 8'd15);
    data_en = 1'b1;

    // Illegal accesses: reserved space and code write
    do_access(2'd3, 8'h40, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("rsvd_sel_cycles", 8'(sel_cycles), 8'd0);
    do_access(2'd1, 8'h20, 8'h55, 1'b1, 8'h00, 1'b0);
    chk("codewr_sel_cycles", 8'(sel_cycles), 8'd0);
    chk("codewr_rdata", last_rd, 8'hFF);

    // Code read
    do_access(2'd1, 8'h20, 8'h00, 1'b0, 8'hC3, 1'b0);
    chk("code_read_rdata", last_rd, 8'hC3);

    // Back-to-back with req held: second sampled in the IDLE after RELEASE
    do_access(2'd2, 8'h37, 8'h00, 1'b0, 8'h3C, 1'b1);
    chk("b2b_first", last_rd, 8'h3C);
    @(negedge clk);
    do_access(2'd2, 8'h37, 8'h00, 1'b0, 8'h3C, 1'b0);
    chk("b2b_second", last_rd, 8'h3C);

    // Reset while data_select is high: no done for the aborted access
    data_en = 1'b0;
    cpu_req = 1'b1; cpu_space = 2'd0; cpu_addr = 8'h10; cpu_wdata = 8'h00; cpu_write = 1'b0;
    sched_sel(cyc + 1, TO, 3'b001, 8'h10, 8'h00, 1'b0);
    sched_done(cyc + 1 + TO, 1'b1, 8'hFF, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_reset_select", {7'd0, data_select}, 8'd1);
    cpu_req = 1'b0;
    reset_pulse(1);
    data_en = 1'b1;
    repeat (20) @(negedge clk);
    do_access(2'd0, 8'h10, 8'h00, 1'b0, 8'h5A, 1'b0);
    chk("post_reset_read", last_rd, 8'h5A);

    // Data write keeps rdata, then read back
    do_access(2'd0, 8'h10, 8'h99, 1'b1, 8'h00, 1'b0);
    chk("data_write_rdata_kept", last_rd, 8'h5A);
    do_access(2'd0, 8'h10, 8'h00, 1'b0, 8'h99, 1'b0);
    chk("data_readback", last_rd, 8'h99);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
